passcode_lock_ctrl: RTL and testbench

Sequencing controller for the 4-digit passcode entry path. It takes debounced one-cycle enter pulses and the 4-bit switch digit, assembles a 16-bit guess MSB-first, and compares it against the stored passcode. It drives unlock/error/lockout status and the digit index/guess word consumed by the seven-segment scan logic. It sits between the debouncer and the display/indicator logic, in the divided-clock domain.

---
 rtl/passcode_lock_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_passcode_lock_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_lock_ctrl.sv
// passcode_lock_ctrl: sequences 4-digit passcode entry, compares the
// assembled guess against the stored passcode, and drives unlock, error
// and lockout status plus the guess/digit index for the display scan.
// Optional feature: define PASS_CHANGE_EN to allow changing the stored
// passcode from UNLOCKED via set_req (adds the SET state).
module passcode_lock_ctrl #(
  parameter logic [15:0] RESET_PASS     = 16'h0000,
  parameter int          MAX_TRIES      = 3,
  parameter int          ERR_CYCLES     = 8,
  parameter int          LOCKOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit_in,
  input  logic        enter_pulse,
  input  logic        lock_req,
  input  logic        set_req,
  output logic [15:0] guess,
  output logic [1:0]  digit_idx,
  output logic        unlocked,
  output logic        error,
  output logic        locked_out,
  output logic [3:0]  fail_count
);

  localparam int TMAX = (ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

`ifdef PASS_CHANGE_EN
  typedef enum logic [2:0] {
    S_ENTRY, S_CHECK, S_UNLOCKED, S_FAIL, S_LOCKOUT, S_SET
  } state_t;
`else
  typedef enum logic [2:0] {
    S_ENTRY, S_CHECK, S_UNLOCKED, S_FAIL, S_LOCKOUT
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   guess_q, guess_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    fc_q, fc_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          unl_q, unl_d;
  logic          err_q, err_d;
  logic          lo_q, lo_d;
  logic [15:0]   stored;
  logic [3:0]    fc_inc;

  // Place a digit into its nibble, MSB-first by entry order.
  function automatic logic [15:0] ins_nibble(input logic [15:0] g,
                                             input logic [1:0]  idx,
                                             input logic [3:0]  d);
    logic [15:0] r;
    r = g;
    case (idx)
      2'd0:    r[15:12] = d;
      2'd1:    r[11:8]  = d;
      2'd2:    r[7:4]   = d;
      default: r[3:0]   = d;
    endcase
    return r;
  endfunction

`ifdef PASS_CHANGE_EN
  logic [15:0] stored_q, stored_d;
  assign stored = stored_q;
`else
  // Without passcode change the stored code is a constant and set_req is unused.
  logic unused_set_req;
  assign unused_set_req = set_req;
  assign stored         = RESET_PASS;
`endif

  // Saturating failure count for the current CHECK.
  assign fc_inc = (fc_q == 4'hF) ? 4'hF : fc_q + 4'd1;

  // Next-state and next-output decode; status bits follow the next state.
  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    tmr_d   = tmr_q;
`ifdef PASS_CHANGE_EN
    stored_d = stored_q;
`endif
    case (state_q)
      S_ENTRY: begin
        if (enter_pulse) begin
          guess_d = ins_nibble(guess_q, idx_q, digit_in);
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (guess_q == stored) begin
          state_d = S_UNLOCKED;
          fc_d    = 4'd0;
        end else begin
          fc_d = fc_inc;
          if (fc_inc == 4'(MAX_TRIES)) begin
            state_d = S_LOCKOUT;
            tmr_d   = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = S_FAIL;
            tmr_d   = TW'(ERR_CYCLES - 1);
          end
        end
      end
      S_FAIL: begin
        if (tmr_q == '0) begin
          state_d = S_ENTRY;
          guess_d = 16'h0000;
          idx_d   = 2'd0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = S_ENTRY;
          guess_d = 16'h0000;
          idx_d   = 2'd0;
          fc_d    = 4'd0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_UNLOCKED: begin
        if (lock_req) begin
          state_d = S_ENTRY;
          guess_d = 16'h0000;
          idx_d   = 2'd0;
        end
`ifdef PASS_CHANGE_EN
        else if (set_req) begin
          state_d = S_SET;
          guess_d = 16'h0000;
          idx_d   = 2'd0;
        end
`endif
      end
`ifdef PASS_CHANGE_EN
      S_SET: begin
        if (lock_req) begin
          state_d = S_ENTRY;
          guess_d = 16'h0000;
          idx_d   = 2'd0;
        end else if (enter_pulse) begin
          guess_d = ins_nibble(guess_q, idx_q, digit_in);
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // New code is committed on the edge its last digit arrives.
            stored_d = ins_nibble(guess_q, idx_q, digit_in);
            guess_d  = 16'h0000;
            state_d  = S_UNLOCKED;
          end
        end
      end
`endif
      default: state_d = S_ENTRY;
    endcase

    unl_d = (state_d == S_UNLOCKED);
`ifdef PASS_CHANGE_EN
    unl_d = unl_d | (state_d == S_SET);
`endif
    err_d = (state_d == S_FAIL);
    lo_d  = (state_d == S_LOCKOUT);
  end

  // State, datapath and registered status with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ENTRY;
      guess_q <= 16'h0000;
      idx_q   <= 2'd0;
      fc_q    <= 4'd0;
      tmr_q   <= '0;
      unl_q   <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      tmr_q   <= tmr_d;
      unl_q   <= unl_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
    end
  end

`ifdef PASS_CHANGE_EN
  // Stored passcode register, reloaded from RESET_PASS on reset.
  always_ff @(posedge clk) begin
    if (reset) stored_q <= RESET_PASS;
    else       stored_q <= stored_d;
  end
`endif

  assign guess      = guess_q;
  assign digit_idx  = idx_q;
  assign unlocked   = unl_q;
  assign error      = err_q;
  assign locked_out = lo_q;
  assign fail_count = fc_q;

endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Testbench for passcode_lock_ctrl: vector table, corner-case sequences,
// and random traffic checked against a behavioural model.
module tb_passcode_lock_ctrl;

  localparam logic [15:0] PASS = 16'h1234;
  localparam int MAXT = 3;
  localparam int ERRC = 8;
  localparam int LOCC = 64;
`ifdef PASS_CHANGE_EN
  localparam bit PCE = 1'b1;
`else
  localparam bit PCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enter_pulse, lock_req, set_req;
  logic [3:0]  digit_in;
  logic [15:0] guess;
  logic [1:0]  digit_idx;
  logic        unlocked, error, locked_out;
  logic [3:0]  fail_count;

  int errors = 0;
  int checks = 0;

  passcode_lock_ctrl #(.RESET_PASS(PASS), .MAX_TRIES(MAXT),
                       .ERR_CYCLES(ERRC), .LOCKOUT_CYCLES(LOCC)) dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .enter_pulse(enter_pulse),
    .lock_req(lock_req), .set_req(set_req), .guess(guess), .digit_idx(digit_idx),
    .unlocked(unlocked), .error(error), .locked_out(locked_out),
    .fail_count(fail_count));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 entry, 1 check, 2 unlocked, 3 error hold, 4 lockout, 5 set
  int          m_mode;
  int          m_rem;
  int          m_fails;
  int          m_digits[$];
  logic [15:0] m_guess;
  logic [15:0] m_stored;

  function automatic logic [15:0] value_of(input int ds[$]);
    int v;
    v = 0;
    foreach (ds[i]) v += ds[i] * (1 << (12 - 4 * i));
    return 16'(v);
  endfunction

  task automatic model_step(input logic r, input logic [3:0] d,
                            input logic e, input logic l, input logic s);
    if (r) begin
      m_mode = 0; m_rem = 0; m_fails = 0; m_digits.delete();
      m_guess = 16'h0; m_stored = PASS;
    end else begin
      case (m_mode)
        0: if (e) begin
             m_digits.push_back(int'(d));
             m_guess = value_of(m_digits);
             if (m_digits.size() == 4) m_mode = 1;
           end
        1: begin
             m_digits.delete();
             if (m_guess == m_stored) begin
               m_mode = 2; m_fails = 0;
             end else begin
               m_fails = (m_fails + 1 > 15) ? 15 : m_fails + 1;
               if (m_fails == MAXT) begin m_mode = 4; m_rem = LOCC; end
               else begin m_mode = 3; m_rem = ERRC; end
             end
           end
        2: if (l) begin
             m_mode = 0; m_guess = 16'h0; m_digits.delete();
           end else if (s && PCE) begin
             m_mode = 5; m_guess = 16'h0; m_digits.delete();
           end
        3: begin
             m_rem--;
             if (m_rem == 0) begin m_mode = 0; m_guess = 16'h0; end
           end
        4: begin
             m_rem--;
             if (m_rem == 0) begin m_mode = 0; m_guess = 16'h0; m_fails = 0; end
           end
        default: if (l) begin
             m_mode = 0; m_guess = 16'h0; m_digits.delete();
           end else if (e) begin
             m_digits.push_back(int'(d));
             if (m_digits.size() == 4) begin
               m_stored = value_of(m_digits);
               m_mode = 2; m_guess = 16'h0; m_digits.delete();
             end else begin
               m_guess = value_of(m_digits);
             end
           end
      endcase
    end
  endtask

  function automatic logic [24:0] ex(input logic [15:0] g, input int idx,
                                     input bit u, input bit er, input bit lo,
                                     input int fc);
    return {g, 2'(idx), u, er, lo, 4'(fc)};
  endfunction

  function automatic logic [24:0] model_out();
    return ex(m_guess, m_digits.size() % 4, (m_mode == 2) || (m_mode == 5),
              m_mode == 3, m_mode == 4, m_fails);
  endfunction

  function automatic logic [24:0] dut_out();
    return {guess, digit_idx, unlocked, error, locked_out, fail_count};
  endfunction

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got guess=%h idx=%0d unl=%b err=%b lo=%b fc=%0d, want guess=%h idx=%0d unl=%b err=%b lo=%b fc=%0d",
               name, act[24:9], act[8:7], act[6], act[5], act[4], act[3:0],
               exp[24:9], exp[8:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, advance model, compare after posedge.
  task automatic cyc(input logic r, input logic [3:0] d, input logic e,
                     input logic l, input logic s);
    @(negedge clk);
    reset = r; digit_in = d; enter_pulse = e; lock_req = l; set_req = s;
    model_step(r, d, e, l, s);
    @(posedge clk); #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) cyc(1'b0, c[15-4*i -: 4], 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  d;
    logic        e, l, s;
    logic [24:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    int cnt;
    reset = 1'b1; digit_in = 4'h0; enter_pulse = 1'b0; lock_req = 1'b0; set_req = 1'b0;

    vt[0] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, ex(16'h0000, 0, 0, 0, 0, 0)};
    vt[1] = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, ex(16'h1000, 1, 0, 0, 0, 0)};
    vt[2] = '{1'b0, 4'h2, 1'b1, 1'b0, 1'b0, ex(16'h1200, 2, 0, 0, 0, 0)};
    vt[3] = '{1'b0, 4'h3, 1'b1, 1'b0, 1'b0, ex(16'h1230, 3, 0, 0, 0, 0)};
    vt[4] = '{1'b0, 4'h4, 1'b1, 1'b0, 1'b0, ex(16'h1234, 0, 0, 0, 0, 0)};
    vt[5] = '{1'b0, 4'h9, 1'b1, 1'b0, 1'b0, ex(16'h1234, 0, 1, 0, 0, 0)};
    vt[6] = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b0, ex(16'h1234, 0, 1, 0, 0, 0)};
    vt[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, ex(16'h0000, 0, 0, 0, 0, 0)};
    vt[8] = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, ex(16'h1000, 1, 0, 0, 0, 0)};
    vt[9] = '{1'b1, 4'h7, 1'b1, 1'b0, 1'b0, ex(16'h0000, 0, 0, 0, 0, 0)};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = vt[i].r; digit_in = vt[i].d; enter_pulse = vt[i].e;
      lock_req = vt[i].l; set_req = vt[i].s;
      model_step(vt[i].r, vt[i].d, vt[i].e, vt[i].l, vt[i].s);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), dut_out(), vt[i].exp);
    end

    // Wrong code: error for ERRC cycles, fail_count 1, then clean entry.
    code(16'h1235);
    chk("check_cycle", dut_out(), ex(16'h1235, 0, 0, 0, 0, 0));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (error) begin
        cnt++;
        chk_int("fail_count_in_err", int'(fail_count), 1);
      end
    end
    chk_int("err_cycles", cnt, ERRC);
    chk("after_err", dut_out(), ex(16'h0000, 0, 0, 0, 0, 1));

    // Two more failures -> lockout, enter pulses ignored throughout.
    code(16'h9999);
    for (int i = 0; i < ERRC + 1; i++) idle();
    code(16'h9999);
    idle();
    chk_int("lockout_start", int'(locked_out), 1);
    cnt = locked_out ? 1 : 0;
    for (int i = 0; i < 100 && locked_out; i++) begin
      cyc(1'b0, 4'(i), 1'b1, 1'b1, 1'b1);
      if (locked_out) cnt++;
    end
    chk_int("lockout_cycles", cnt, LOCC);
    chk("after_lockout", dut_out(), ex(16'h0000, 0, 0, 0, 0, 0));

    // Reset mid-entry discards digits, then correct code unlocks.
    cyc(1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    chk("reset_mid_entry", dut_out(), ex(16'h0000, 0, 0, 0, 0, 0));
    code(16'h1234);
    idle();
    chk("unlock_after_reset", dut_out(), ex(16'h1234, 0, 1, 0, 0, 0));

    // lock_req and set_req together: relock, stored code unchanged.
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    chk("lock_wins", dut_out(), ex(16'h0000, 0, 0, 0, 0, 0));
    code(16'h1234);
    idle();
    chk_int("relock_unlock", int'(unlocked), 1);

`ifdef PASS_CHANGE_EN
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    code(16'hABCD);
    chk("set_done", dut_out(), ex(16'h0000, 0, 1, 0, 0, 0));
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    code(16'hABCD);
    idle();
    chk_int("new_code_unlocks", int'(unlocked), 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    code(16'h1234);
    idle();
    chk_int("old_code_fails", int'(error), 1);
`endif

    // Random traffic; digits lean toward the stored code so unlocks happen.
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      int pos;
      pos = m_digits.size() % 4;
      d = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15))
                                      : m_stored[15-4*pos -: 4];
      cyc(($urandom_range(0, 199) == 0), d, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
